// File: rtl/step_pulse_gen.sv
// rtl/step_pulse_gen.sv - debounced manual and periodic auto step pulse generator
// Produces single-cycle step pulses and keeps a wrapping 8-bit step count.
module step_pulse_gen #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned AUTO_PERIOD     = 8
) (
   input  logic       clk_2,
   input  logic       reset,
   input  logic       btn_raw,
   input  logic       auto_en,
   output logic       step,
   output logic       level,
   output logic [7:0] step_count
);

   typedef enum logic [1:0] {
      ST_LOW       = 2'd0,
      ST_WAIT_HIGH = 2'd1,
      ST_HIGH      = 2'd2,
      ST_WAIT_LOW  = 2'd3
   } db_state_t;

   localparam logic [7:0]  DCNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [15:0] PCNT_LAST = 16'(AUTO_PERIOD - 1);

   logic        s1_q, s2_q;
   db_state_t   state_q, state_d;
   logic [7:0]  dcnt_q, dcnt_d;
   logic [15:0] pcnt_q, pcnt_d;
   logic        step_q, step_d;
   logic        level_q, level_d;
   logic [7:0]  count_q, count_d;
   logic        manual_tick, auto_tick;

   always_ff @(posedge clk_2) begin
      if (reset) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         state_q <= ST_LOW;
         dcnt_q  <= 8'd0;
         pcnt_q  <= 16'd0;
         step_q  <= 1'b0;
         level_q <= 1'b0;
         count_q <= 8'd0;
      end else begin
         s1_q    <= btn_raw;
         s2_q    <= s1_q;
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         pcnt_q  <= pcnt_d;
         step_q  <= step_d;
         level_q <= level_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      case (state_q)
         ST_LOW: begin
            if (s2_q) begin
               state_d = ST_WAIT_HIGH;
               dcnt_d  = 8'd1;
            end
         end
         ST_WAIT_HIGH: begin
            if (!s2_q) begin
               state_d = ST_LOW;
               dcnt_d  = 8'd0;
            end else if (dcnt_q == DCNT_LAST) begin
               state_d = ST_HIGH;
               dcnt_d  = 8'd0;
            end else begin
               dcnt_d  = dcnt_q + 8'd1;
            end
         end
         ST_HIGH: begin
            if (!s2_q) begin
               state_d = ST_WAIT_LOW;
               dcnt_d  = 8'd1;
            end
         end
         ST_WAIT_LOW: begin
            if (s2_q) begin
               state_d = ST_HIGH;
               dcnt_d  = 8'd0;
            end else if (dcnt_q == DCNT_LAST) begin
               state_d = ST_LOW;
               dcnt_d  = 8'd0;
            end else begin
               dcnt_d  = dcnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_LOW;
            dcnt_d  = 8'd0;
         end
      endcase
   end

   // Only the accepted rising edge ticks; the falling side is silent.
   always_comb begin
      level_d     = (state_d == ST_HIGH) || (state_d == ST_WAIT_LOW);
      manual_tick = (state_q == ST_WAIT_HIGH) && (state_d == ST_HIGH);
   end

   always_comb begin
      pcnt_d    = 16'd0;
      auto_tick = 1'b0;
      if (auto_en) begin
         if (pcnt_q == PCNT_LAST) begin
            auto_tick = 1'b1;
         end else begin
            pcnt_d = pcnt_q + 16'd1;
         end
      end
   end

   always_comb begin
      step_d  = manual_tick | auto_tick;
      count_d = count_q + {7'd0, step_d};
   end

   assign step       = step_q;
   assign level      = level_q;
   assign step_count = count_q;

endmodule

// File: doc/step_pulse_gen.md
STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

Interface
REQ-001 The block SHALL have a parameter DEBOUNCE_CYCLES, default 4, giving the number of consecutive equal synchronized samples needed to accept a new button level; legal range 2..255.
REQ-002 The block SHALL have a parameter AUTO_PERIOD, default 8, giving the automatic step period in clk_2 cycles; legal range 2..65535.
REQ-003 The block SHALL have port clk_2, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port btn_raw, input, 1 bit: asynchronous, bouncy switch or button level.
REQ-006 The block SHALL have port auto_en, input, 1 bit: synchronous enable for automatic stepping.
REQ-007 The block SHALL have port step, output, 1 bit: single-cycle step-enable pulse for the downstream one-hot ring counter.
REQ-008 The block SHALL have port level, output, 1 bit: debounced button level.
REQ-009 The block SHALL have port step_count, output, 8 bits: total steps issued, for LED display.

Function
REQ-010 btn_raw SHALL pass through a 2-flop synchronizer (s1, then s2); only s2 feeds the debounce FSM.
REQ-011 The debounce FSM SHALL have states LOW, WAIT_HIGH, HIGH and WAIT_LOW, plus a consecutive-sample counter dcnt.
REQ-012 LOW transitions: s2=1 -> WAIT_HIGH with dcnt=1; otherwise stay in LOW.
REQ-013 WAIT_HIGH transitions:
  - s2=0 -> LOW with dcnt=0;
  - s2=1 and dcnt==DEBOUNCE_CYCLES-1 -> HIGH with dcnt=0;
  - otherwise dcnt increments.
REQ-014 HIGH and WAIT_LOW SHALL mirror REQ-012 and REQ-013 with the polarity of s2 inverted and the target states swapped.
REQ-015 level SHALL be 1 in HIGH and WAIT_LOW, and 0 in LOW and WAIT_HIGH; it SHALL be registered.
REQ-016 Manual tick: the clock edge that moves WAIT_HIGH -> HIGH SHALL also set step=1 for exactly the following cycle.
REQ-017 The manual-path latency SHALL be exact: for btn_raw held high, step rises after the (DEBOUNCE_CYCLES+2)th rising edge following the btn_raw rise (6 edges at the defaults).
REQ-018 Only the rising debounced edge SHALL generate a tick; HIGH -> LOW generates none, and holding the button generates exactly one tick.
REQ-019 Any s2 excursion shorter than DEBOUNCE_CYCLES consecutive samples SHALL produce no change in level and no step.
REQ-020 The auto tick SHALL be driven by a period counter pcnt (16 bits) that behaves as follows:
  - auto_en=0 -> pcnt=0;
  - auto_en=1 and pcnt==AUTO_PERIOD-1 -> pcnt=0 and an auto tick;
  - otherwise pcnt increments.
REQ-021 The first auto step SHALL occur after the AUTO_PERIOD-th consecutive edge with auto_en=1, then every AUTO_PERIOD cycles; deasserting auto_en mid-period discards the partial count.
REQ-022 step SHALL be registered, equal to (manual tick OR auto tick), and never high for 2 or more consecutive cycles from a single event.
REQ-023 Coincident manual and auto ticks SHALL yield one step cycle and increment step_count by 1.
REQ-024 Back-to-back auto ticks cannot occur, since AUTO_PERIOD is at least 2.
REQ-025 step_count SHALL increment by 1 on every edge at which step is set, wrapping 255 -> 0 with no flag.

Reset
REQ-026 When reset=1 at a clock edge, that edge SHALL set:
  - s1, s2 = 0;
  - FSM state = LOW, dcnt = 0;
  - pcnt = 0;
  - step = 0, level = 0, step_count = 0.
REQ-027 Reset SHALL override all other inputs, including mid-debounce or mid-period; a tick pending on that edge is dropped.
REQ-028 If btn_raw is held high through reset release, the FSM SHALL re-debounce from LOW and issue exactly one step after DEBOUNCE_CYCLES+2 edges.
REQ-029 Outputs SHALL be defined, and not X, from the first edge on which reset=1.

Verification (DEBOUNCE_CYCLES=4, AUTO_PERIOD=8)
REQ-030 Clean press: reset, then btn_raw=1 held -> step=1 for one cycle after edge 6, level=1, step_count=1; no further steps while held.
REQ-031 Bounce: btn_raw toggles 1,0,1,1,0 (one value per cycle) then stays 0 -> step never 1, level stays 0, step_count=0.
REQ-032 Auto: auto_en=1 for 24 edges -> step pulses after edges 8, 16 and 24, step_count=3; then auto_en=0 for 5 edges and back to 1 -> next step 8 edges later.
REQ-033 Coincidence and wrap:
  - a press timed so that the manual tick lands on auto edge 8 -> one step cycle, step_count +1;
  - preload to 255 via 255 auto steps, then one more step -> step_count=0.
REQ-034 Reset mid-operation: reset=1 at auto edge 5 while btn_raw is high -> all outputs 0 on the next cycle; after release with btn_raw still high -> one step after edge 6; auto restarts with pcnt=0.
